cmp_frame_deframer: RTL

Parametrised comparator-fiber frame deframer. It sits behind the buffer-bypass GTX receiver, in the recovered CMP_RX_CLK160 domain. It takes the 16-bit 8b10b-decoded word stream, finds the K-char sync word, and runs a hunt/check/lock state machine. It assembles frames of NWORDS words into one wide payload, and keeps saturating sync-error and code-error counters for link monitoring. It generalises fixed 4-word framing to any frame length, and adds lock hysteresis and error accounting.

---
 rtl/cmp_frame_deframer_if.sv | 32 +++
 rtl/cmp_frame_deframer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cmp_frame_deframer_if.sv
// Decoded-word input bundle and assembled-frame/monitor output bundle for cmp_frame_deframer.
interface cmp_frame_deframer_if #(
  parameter int unsigned NWORDS = 4,
  parameter int unsigned ERRW   = 8
);
  logic [15:0]              RX_DATA;
  logic [1:0]               RX_ISK;
  logic [1:0]               RX_DISPERR;
  logic [1:0]               RX_NOTINTABLE;
  logic                     ERR_CLR;
  logic [(NWORDS-1)*16-1:0] RCV_DATA;
  logic                     FRAME_VALID;
  logic [NWORDS-2:0]        NONZERO_WORD;
  logic                     LTNCY_TRIG;
  logic [NWORDS-1:0]        CEW;
  logic                     LOCKED;
  logic                     SYNCLOST;
  logic [ERRW-1:0]          SYNC_ERR_CNT;
  logic [ERRW-1:0]          CODE_ERR_CNT;

  modport master (
    output RX_DATA, RX_ISK, RX_DISPERR, RX_NOTINTABLE, ERR_CLR,
    input  RCV_DATA, FRAME_VALID, NONZERO_WORD, LTNCY_TRIG, CEW,
           LOCKED, SYNCLOST, SYNC_ERR_CNT, CODE_ERR_CNT
  );

  modport slave (
    input  RX_DATA, RX_ISK, RX_DISPERR, RX_NOTINTABLE, ERR_CLR,
    output RCV_DATA, FRAME_VALID, NONZERO_WORD, LTNCY_TRIG, CEW,
           LOCKED, SYNCLOST, SYNC_ERR_CNT, CODE_ERR_CNT
  );
endinterface

// File: rtl/cmp_frame_deframer.sv
// Comparator-fiber deframer: K-sync hunt/check/lock, NWORDS-word payload assembly, saturating error counters.
// Optional: define CMP_DEFRAME_ERR_GATE_EN to discard frames with code errors and count them as bad frames.
module cmp_frame_deframer #(
  parameter int unsigned NWORDS     = 4,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 2,
  parameter int unsigned ERRW       = 8,
  parameter logic [7:0]  SYNC_CODE  = 8'hBC,
  parameter logic [7:0]  LT_CODE    = 8'hFC
) (
  input logic                 CMP_RX_CLK160,
  input logic                 cmp_rx_resetdone,
  cmp_frame_deframer_if.slave link
);
  localparam int unsigned PHW = $clog2(NWORDS);
  localparam int unsigned PW  = (NWORDS-1)*16;
  localparam int unsigned GW  = $clog2(LOCK_CNT+1);
  localparam int unsigned BW  = $clog2(UNLOCK_CNT+1);

  typedef enum logic [1:0] {ST_HUNT, ST_CHECK, ST_LOCKED, ST_LOST} state_t;

  state_t            state_q, state_d;
  logic [PHW-1:0]    ph_q, ph_d, ph_inc;
  logic [GW-1:0]     good_q, good_d;
  logic [BW-1:0]     bad_q, bad_d;
  logic [PW-1:0]     sh_q, sh_d, rcv_q, rcv_d;
  logic [NWORDS-2:0] nz_q, nz_d;
  logic [NWORDS-1:0] cew_q, cew_d;
  logic              lt_q, lt_d, ltout_q, ltout_d, fv_q, fv_d;
  logic [ERRW-1:0]   serr_q, serr_d, cerr_q, cerr_d;
  logic              is_sync, code_err, in_frame, last_ph;
  logic              sync_bad, good_frame, bad_ev, emit_ok;
`ifdef CMP_DEFRAME_ERR_GATE_EN
  logic              fcerr_q, fcerr_d, fsbad_q, fsbad_d, frame_cerr, frame_sbad;
`endif

  always_comb begin
    is_sync    = (link.RX_ISK == 2'b01) &&
                 ((link.RX_DATA[7:0] == SYNC_CODE) || (link.RX_DATA[7:0] == LT_CODE));
    code_err   = (|link.RX_DISPERR) || (|link.RX_NOTINTABLE);
    in_frame   = (state_q == ST_CHECK) || (state_q == ST_LOCKED);
    last_ph    = (ph_q == PHW'(NWORDS-1));
    ph_inc     = last_ph ? '0 : ph_q + 1'b1;
    // Missing sync in slot 0 and misplaced sync elsewhere are the same mismatch.
    sync_bad   = in_frame && ((ph_q == '0) != is_sync);
    good_frame = in_frame && (ph_q == '0) && is_sync;
`ifdef CMP_DEFRAME_ERR_GATE_EN
    frame_cerr = code_err || (fcerr_q && (ph_q != '0));
    frame_sbad = sync_bad || (fsbad_q && (ph_q != '0));
    fcerr_d    = frame_cerr;
    fsbad_d    = frame_sbad;
    bad_ev     = sync_bad || (in_frame && last_ph && frame_cerr && !frame_sbad);
    emit_ok    = !frame_cerr;
`else
    bad_ev     = sync_bad;
    emit_ok    = 1'b1;
`endif

    sh_d = sh_q;
    for (int unsigned k = 1; k + 1 < NWORDS; k++) begin
      if (ph_q == PHW'(k)) sh_d[(k-1)*16 +: 16] = link.RX_DATA;
    end

    lt_d = lt_q;
    if (ph_q == '0) lt_d = is_sync && (link.RX_DATA[7:0] == LT_CODE);

    rcv_d   = rcv_q;
    nz_d    = nz_q;
    ltout_d = ltout_q;
    fv_d    = 1'b0;
    if ((state_q == ST_LOCKED) && last_ph && emit_ok) begin
      rcv_d = sh_q;
      rcv_d[(NWORDS-2)*16 +: 16] = link.RX_DATA;
      for (int unsigned k = 0; k + 1 < NWORDS; k++) nz_d[k] = |rcv_d[k*16 +: 16];
      ltout_d = lt_q;
      fv_d    = 1'b1;
    end

    serr_d = serr_q;
    cerr_d = cerr_q;
    if (bad_ev && (serr_q != '1)) serr_d = serr_q + 1'b1;
    if (code_err && (cerr_q != '1)) cerr_d = cerr_q + 1'b1;
    if (link.ERR_CLR) begin
      serr_d = '0;
      cerr_d = '0;
    end

    state_d = state_q;
    ph_d    = ph_inc;
    good_d  = good_q;
    bad_d   = bad_q;
    case (state_q)
      ST_HUNT: begin
        ph_d = '0;
        if (is_sync) begin
          ph_d    = PHW'(1);
          good_d  = GW'(1);
          bad_d   = '0;
          state_d = (LOCK_CNT <= 1) ? ST_LOCKED : ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (bad_ev) begin
          state_d = ST_HUNT;
          ph_d    = '0;
          good_d  = '0;
        end else if (good_frame) begin
          good_d = good_q + 1'b1;
          if (good_q == GW'(LOCK_CNT-1)) begin
            state_d = ST_LOCKED;
            bad_d   = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (bad_ev) begin
          bad_d = bad_q + 1'b1;
          if (bad_q == BW'(UNLOCK_CNT-1)) state_d = ST_LOST;
        end else if (good_frame) begin
          bad_d = '0;
        end
      end
      ST_LOST: begin
        state_d = ST_HUNT;
        ph_d    = '0;
        good_d  = '0;
        bad_d   = '0;
      end
      default: state_d = ST_HUNT;
    endcase

    cew_d = '0;
    if ((state_d == ST_CHECK) || (state_d == ST_LOCKED)) begin
      for (int unsigned k = 0; k < NWORDS; k++) cew_d[k] = (ph_d == PHW'(k));
    end
  end

  always_ff @(posedge CMP_RX_CLK160 or negedge cmp_rx_resetdone) begin
    if (!cmp_rx_resetdone) begin
      state_q <= ST_HUNT;
      ph_q    <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      sh_q    <= '0;
      rcv_q   <= '0;
      nz_q    <= '0;
      cew_q   <= '0;
      lt_q    <= 1'b0;
      ltout_q <= 1'b0;
      fv_q    <= 1'b0;
      serr_q  <= '0;
      cerr_q  <= '0;
`ifdef CMP_DEFRAME_ERR_GATE_EN
      fcerr_q <= 1'b0;
      fsbad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      sh_q    <= sh_d;
      rcv_q   <= rcv_d;
      nz_q    <= nz_d;
      cew_q   <= cew_d;
      lt_q    <= lt_d;
      ltout_q <= ltout_d;
      fv_q    <= fv_d;
      serr_q  <= serr_d;
      cerr_q  <= cerr_d;
`ifdef CMP_DEFRAME_ERR_GATE_EN
      fcerr_q <= fcerr_d;
      fsbad_q <= fsbad_d;
`endif
    end
  end

  assign link.RCV_DATA     = rcv_q;
  assign link.FRAME_VALID  = fv_q;
  assign link.NONZERO_WORD = nz_q;
  assign link.LTNCY_TRIG   = ltout_q;
  assign link.CEW          = cew_q;
  assign link.LOCKED       = (state_q == ST_LOCKED);
  assign link.SYNCLOST     = (state_q == ST_LOST);
  assign link.SYNC_ERR_CNT = serr_q;
  assign link.CODE_ERR_CNT = cerr_q;
endmodule
